gfx256_fragment: RTL and testbench

Fragment stage directly downstream of the clip/z-test stage in the gfx256 pipeline. Accepts one surviving pixel at a time over the clip stage's write/ack handshake and optionally samples texture 0 via the shared wishbone reader, replacing the flat colour with the texel. Applies a colour-key discard and hands the pixel to the blender over a second write/ack handshake.

---
 rtl/gfx256_pkg.sv | 24 ++
 rtl/gfx256_fragment_if.sv | 29 ++
 rtl/gfx256_texel_unpack.sv | 31 +++
 rtl/gfx256_fragment.sv | 248 ++++++++++++++++++++++++
 tb/tb_gfx256_fragment.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gfx256_pkg.sv
// gfx256_pkg
//   Shared types and helpers for the gfx256 fragment stage.
//   - fragment_state_e   : fragment FSM encoding
//   - COLORKEY_W         : width of the expanded texel / colour key compare
//   - rgb565_to_argb8888 : opaque ARGB8888 expansion of an RGB565 texel
package gfx256_pkg;

    localparam int COLORKEY_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        TEX_REQ = 3'd2,
        WRITE   = 3'd3,
        ACK     = 3'd4
    } fragment_state_e;

    // Channel MSBs are replicated into the low bits so that full-scale 565
    // maps to full-scale 8888 (0x1F -> 0xFF, 0x3F -> 0xFF).
    function automatic logic [COLORKEY_W-1:0] rgb565_to_argb8888(input logic [15:0] p);
        return {8'hFF, p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/gfx256_fragment_if.sv
// gfx256_fragment_if
//   Texture read bus between the fragment stage and the shared wishbone
//   line reader.
//   texture_addr    : 32-byte aligned line address       (master -> slave)
//   texture_sel     : byte lanes of the texel in the line (master -> slave)
//   texture_request : read request, held until ack        (master -> slave)
//   texture_ack     : read data valid                     (slave -> master)
//   texture_data    : returned MDW-bit line               (slave -> master)
//   wbm_busy        : reader busy, no new request         (slave -> master)
interface gfx256_fragment_if #(
    parameter int MDW = 256
);
    logic [31:0]    texture_addr;
    logic [31:0]    texture_sel;
    logic           texture_request;
    logic           texture_ack;
    logic [MDW-1:0] texture_data;
    logic           wbm_busy;

    modport master (
        output texture_addr, texture_sel, texture_request,
        input  texture_ack, texture_data, wbm_busy
    );

    modport slave (
        input  texture_addr, texture_sel, texture_request,
        output texture_ack, texture_data, wbm_busy
    );
endinterface

// File: rtl/gfx256_texel_unpack.sv
// gfx256_texel_unpack
//   Combinational extraction of one texel from a returned memory line.
//   line_i      : MDW-bit line from the reader
//   byte_off_i  : byte offset of the texel within the line
//   tex_32bpp_i : 1 = ARGB8888 (32-bit lane), 0 = RGB565 (16-bit lane)
//   texel_o     : texel expanded to ARGB8888
module gfx256_texel_unpack
    import gfx256_pkg::*;
#(
    parameter int MDW = 256
) (
    input  logic [MDW-1:0]        line_i,
    input  logic [4:0]            byte_off_i,
    input  logic                  tex_32bpp_i,
    output logic [COLORKEY_W-1:0] texel_o
);

    logic [31:0] lane32;
    logic [15:0] lane16;
    // Byte 0 never selects a lane: texels are 2- or 4-byte aligned in the line.
    logic        unused_byte0;

    assign unused_byte0 = byte_off_i[0];

    always_comb begin
        lane32  = line_i[{byte_off_i[4:2], 5'b0} +: 32];
        lane16  = line_i[{byte_off_i[4:1], 4'b0} +: 16];
        texel_o = tex_32bpp_i ? lane32 : rgb565_to_argb8888(lane16);
    end

endmodule

// File: rtl/gfx256_fragment.sv
// gfx256_fragment
//   Fragment stage behind clip/z-test. Takes one pixel at a time, optionally
//   replaces its colour with a texel of texture 0, applies the colour-key
//   discard and forwards the pixel to the blender.
//   clk_i, rst_ni                    : clock, async active-low reset
//   texture_enable_i, tex_32bpp_i    : texturing on / texel format
//   colorkey_enable_i, colorkey_i    : colour-key discard
//   tex0_base_i, tex0_size_{x,y}_i   : texture placement and dimensions
//   pixel_{x,y,z}_i, u_i, v_i, a_i,
//   color_i, write_i, ack_o          : pixel from clip (write/ack handshake)
//   tex                              : texture read bus (master side)
//   pixel_{x,y,z}_o, color_o, a_o,
//   write_o, ack_i                   : pixel to blender (write/ack handshake)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for write_i; captures pixel into holding regs
//   ADDR    | clamps u/v, computes line address and byte lanes
//   TEX_REQ | issues read when reader not busy, waits for texture_ack
//   WRITE   | write_o high until blender ack_i
//   ACK     | one-cycle ack_o to clip (pixel written or discarded)
module gfx256_fragment
    import gfx256_pkg::*;
#(
    parameter int point_width = 16,
    parameter int MDW         = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   texture_enable_i,
    input  logic                   tex_32bpp_i,
    input  logic                   colorkey_enable_i,
    input  logic [COLORKEY_W-1:0]  colorkey_i,
    input  logic [31:0]            tex0_base_i,
    input  logic [point_width-1:0] tex0_size_x_i,
    input  logic [point_width-1:0] tex0_size_y_i,

    input  logic [point_width-1:0] pixel_x_i,
    input  logic [point_width-1:0] pixel_y_i,
    input  logic [point_width-1:0] pixel_z_i,
    input  logic [point_width-1:0] u_i,
    input  logic [point_width-1:0] v_i,
    input  logic [7:0]             a_i,
    input  logic [31:0]            color_i,
    input  logic                   write_i,
    output logic                   ack_o,

    gfx256_fragment_if.master      tex,

    output logic [point_width-1:0] pixel_x_o,
    output logic [point_width-1:0] pixel_y_o,
    output logic [point_width-1:0] pixel_z_o,
    output logic [31:0]            color_o,
    output logic [7:0]             a_o,
    output logic                   write_o,
    input  logic                   ack_i
);

    fragment_state_e        state_q, state_d;

    logic [point_width-1:0] px_q, px_d;
    logic [point_width-1:0] py_q, py_d;
    logic [point_width-1:0] pz_q, pz_d;
    logic [point_width-1:0] u_q, u_d;
    logic [point_width-1:0] v_q, v_d;
    logic [31:0]            color_q, color_d;
    logic [7:0]             a_q, a_d;
    logic                   write_q, write_d;
    logic                   ack_q, ack_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            sel_q, sel_d;
    logic                   req_q, req_d;
    logic                   b32_q, b32_d;
    logic                   ck_en_q, ck_en_d;
    logic [COLORKEY_W-1:0]  ck_q, ck_d;
    logic [4:0]             byte_lo_q, byte_lo_d;

    logic [point_width-1:0] sx_eff, sy_eff;
    logic [point_width-1:0] sx_max, sy_max;
    logic [point_width-1:0] uc, vc;
    logic [31:0]            off_texels;
    logic [31:0]            off_bytes;
    logic [31:0]            tex_byte_addr;
    logic [COLORKEY_W-1:0]  texel;

    gfx256_texel_unpack #(
        .MDW (MDW)
    ) u_unpack (
        .line_i      (tex.texture_data),
        .byte_off_i  (byte_lo_q),
        .tex_32bpp_i (b32_q),
        .texel_o     (texel)
    );

    // Texel address math; only consumed in ADDR, so the config inputs feed
    // the pixel only during that one cycle.
    always_comb begin
        sx_eff        = (tex0_size_x_i == '0) ? point_width'(1) : tex0_size_x_i;
        sy_eff        = (tex0_size_y_i == '0) ? point_width'(1) : tex0_size_y_i;
        sx_max        = sx_eff - point_width'(1);
        sy_max        = sy_eff - point_width'(1);
        uc            = (u_q > sx_max) ? sx_max : u_q;
        vc            = (v_q > sy_max) ? sy_max : v_q;
        off_texels    = 32'(vc) * 32'(sx_eff) + 32'(uc);
        off_bytes     = tex_32bpp_i ? (off_texels << 2) : (off_texels << 1);
        tex_byte_addr = tex0_base_i + off_bytes;
    end

    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        pz_d      = pz_q;
        u_d       = u_q;
        v_d       = v_q;
        color_d   = color_q;
        a_d       = a_q;
        write_d   = write_q;
        ack_d     = 1'b0;
        addr_d    = addr_q;
        sel_d     = sel_q;
        req_d     = req_q;
        b32_d     = b32_q;
        ck_en_d   = ck_en_q;
        ck_d      = ck_q;
        byte_lo_d = byte_lo_q;

        unique case (state_q)
            IDLE: begin
                if (write_i) begin
                    px_d    = pixel_x_i;
                    py_d    = pixel_y_i;
                    pz_d    = pixel_z_i;
                    u_d     = u_i;
                    v_d     = v_i;
                    color_d = color_i;
                    a_d     = a_i;
                    if (texture_enable_i) begin
                        state_d = ADDR;
                    end else begin
                        write_d = 1'b1;
                        state_d = WRITE;
                    end
                end
            end

            ADDR: begin
                b32_d     = tex_32bpp_i;
                ck_en_d   = colorkey_enable_i;
                ck_d      = colorkey_i;
                addr_d    = {tex_byte_addr[31:5], 5'b0};
                sel_d     = (tex_32bpp_i ? 32'hF : 32'h3) << tex_byte_addr[4:0];
                byte_lo_d = tex_byte_addr[4:0];
                state_d   = TEX_REQ;
            end

            TEX_REQ: begin
                // An ack is only meaningful once our request is on the bus.
                if (!req_q) begin
                    if (!tex.wbm_busy) begin
                        req_d = 1'b1;
                    end
                end else if (tex.texture_ack) begin
                    req_d = 1'b0;
                    if (ck_en_q && (texel == ck_q)) begin
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        color_d = texel;
                        // a_in * A / 255 approximated as a_in * (A + 1) >> 8
                        a_d     = 8'((16'(a_q) * (16'(texel[31:24]) + 16'd1)) >> 8);
                        write_d = 1'b1;
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                if (ack_i) begin
                    write_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            px_q      <= '0;
            py_q      <= '0;
            pz_q      <= '0;
            u_q       <= '0;
            v_q       <= '0;
            color_q   <= '0;
            a_q       <= '0;
            write_q   <= 1'b0;
            ack_q     <= 1'b0;
            addr_q    <= '0;
            sel_q     <= '0;
            req_q     <= 1'b0;
            b32_q     <= 1'b0;
            ck_en_q   <= 1'b0;
            ck_q      <= '0;
            byte_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pz_q      <= pz_d;
            u_q       <= u_d;
            v_q       <= v_d;
            color_q   <= color_d;
            a_q       <= a_d;
            write_q   <= write_d;
            ack_q     <= ack_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            req_q     <= req_d;
            b32_q     <= b32_d;
            ck_en_q   <= ck_en_d;
            ck_q      <= ck_d;
            byte_lo_q <= byte_lo_d;
        end
    end

    assign pixel_x_o           = px_q;
    assign pixel_y_o           = py_q;
    assign pixel_z_o           = pz_q;
    assign color_o             = color_q;
    assign a_o                 = a_q;
    assign write_o             = write_q;
    assign ack_o               = ack_q;
    assign tex.texture_addr    = addr_q;
    assign tex.texture_sel     = sel_q;
    assign tex.texture_request = req_q;

endmodule

// File: tb/tb_gfx256_fragment.sv
module tb_gfx256_fragment;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        texture_enable_i, tex_32bpp_i, colorkey_enable_i;
    logic [31:0] colorkey_i, tex0_base_i, color_i;
    logic [15:0] tex0_size_x_i, tex0_size_y_i;
    logic [15:0] pixel_x_i, pixel_y_i, pixel_z_i, u_i, v_i;
    logic [7:0]  a_i;
    logic        write_i, ack_o;
    logic [15:0] pixel_x_o, pixel_y_o, pixel_z_o;
    logic [31:0] color_o;
    logic [7:0]  a_o;
    logic        write_o, ack_i;

    gfx256_fragment_if #(.MDW(256)) tex ();

    gfx256_fragment #(.point_width(16), .MDW(256)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .texture_enable_i  (texture_enable_i),
        .tex_32bpp_i       (tex_32bpp_i),
        .colorkey_enable_i (colorkey_enable_i),
        .colorkey_i        (colorkey_i),
        .tex0_base_i       (tex0_base_i),
        .tex0_size_x_i     (tex0_size_x_i),
        .tex0_size_y_i     (tex0_size_y_i),
        .pixel_x_i         (pixel_x_i),
        .pixel_y_i         (pixel_y_i),
        .pixel_z_i         (pixel_z_i),
        .u_i               (u_i),
        .v_i               (v_i),
        .a_i               (a_i),
        .color_i           (color_i),
        .write_i           (write_i),
        .ack_o             (ack_o),
        .tex               (tex),
        .pixel_x_o         (pixel_x_o),
        .pixel_y_o         (pixel_y_o),
        .pixel_z_o         (pixel_z_o),
        .color_o           (color_o),
        .a_o               (a_o),
        .write_o           (write_o),
        .ack_i             (ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          tex_en, b32, ck_en;
        logic [31:0] ck, base;
        logic [15:0] sx, sy, u, v;
        logic [7:0]  a;
        logic [31:0] color, raw;
        int          busy, ack_dly;
        logic [31:0] e_addr, e_sel, e_color;
        logic [7:0]  e_a;
        bit          e_disc;
    } vec_t;

    typedef struct {
        logic [31:0] color;
        logic [7:0]  a;
        logic [15:0] x, y, z;
        bit          disc;
    } exp_t;

    exp_t sb[$];
    vec_t vt[10];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input bit te, input bit b32, input bit cke, input logic [31:0] ck,
                                input logic [31:0] base, input logic [15:0] sx, input logic [15:0] sy,
                                input logic [15:0] u, input logic [15:0] v, input logic [7:0] a,
                                input logic [31:0] col, input logic [31:0] raw, input int busy,
                                input int dly, input logic [31:0] ea, input logic [31:0] es,
                                input logic [31:0] ec, input logic [7:0] eaa, input bit ed);
        vec_t t;
        t.tex_en = te; t.b32 = b32; t.ck_en = cke; t.ck = ck; t.base = base;
        t.sx = sx; t.sy = sy; t.u = u; t.v = v; t.a = a; t.color = col; t.raw = raw;
        t.busy = busy; t.ack_dly = dly; t.e_addr = ea; t.e_sel = es; t.e_color = ec;
        t.e_a = eaa; t.e_disc = ed;
        return t;
    endfunction

    function automatic logic [255:0] build_line(input vec_t t);
        logic [255:0] line;
        int lane;
        line = {8{32'hA5C35A3C}};
        lane = 0;
        for (int b = 31; b >= 0; b--) if (t.e_sel[b]) lane = b;
        if (t.b32) line[lane*8 +: 32] = t.raw;
        else       line[lane*8 +: 16] = t.raw[15:0];
        return line;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_pixel(input vec_t t, input int id);
        texture_enable_i  = t.tex_en;
        tex_32bpp_i       = t.b32;
        colorkey_enable_i = t.ck_en;
        colorkey_i        = t.ck;
        tex0_base_i       = t.base;
        tex0_size_x_i     = t.sx;
        tex0_size_y_i     = t.sy;
        u_i               = t.u;
        v_i               = t.v;
        a_i               = t.a;
        color_i           = t.color;
        pixel_x_i         = 16'(100 + id);
        pixel_y_i         = 16'(200 + id);
        pixel_z_i         = 16'(16'h8000 + id);
    endtask

    task automatic run_vec(input vec_t t, input int id);
        int cyc, req_cyc, texack_cyc, ackset_cyc, req_wait, ack_wait;
        bit req_seen, wrote, done;
        logic [255:0] line;
        exp_t e, g;
        string p;
        p = $sformatf("v%0d", id);
        drive_pixel(t, id);
        tex.wbm_busy = (t.busy > 0);
        e.color = t.e_color; e.a = t.e_a; e.disc = t.e_disc;
        e.x = pixel_x_i; e.y = pixel_y_i; e.z = pixel_z_i;
        sb.push_back(e);
        line = build_line(t);
        write_i = 1'b1;
        cyc = 0; req_cyc = 0; texack_cyc = 0; ackset_cyc = 0;
        req_wait = -1; ack_wait = -1;
        req_seen = 0; wrote = 0; done = 0;
        while (!done && cyc < 100) begin
            step();
            cyc++;
            tex.texture_ack = 1'b0;
            ack_i = 1'b0;
            if (t.busy > 0 && cyc == t.busy) tex.wbm_busy = 1'b0;
            if (tex.texture_request && !req_seen) begin
                req_seen = 1;
                req_cyc = cyc;
                chk({p, "_addr"}, tex.texture_addr, t.e_addr);
                chk({p, "_sel"}, tex.texture_sel, t.e_sel);
                chk({p, "_req_cycle"}, req_cyc, (t.busy == 0) ? 3 : t.busy + 1);
                // change every input mid-pixel; the captured values must hold
                texture_enable_i  = ~t.tex_en;
                tex_32bpp_i       = ~t.b32;
                colorkey_enable_i = ~t.ck_en;
                colorkey_i        = ~t.ck;
                tex0_base_i       = 32'hDEAD0000;
                tex0_size_x_i     = 16'h3;
                tex0_size_y_i     = 16'h3;
                u_i = 16'h5; v_i = 16'h5;
                a_i = ~t.a; color_i = ~t.color;
                pixel_x_i = 16'hFFFF; pixel_y_i = 16'hFFFF; pixel_z_i = 16'hFFFF;
                ack_i = 1'b1;
                req_wait = 2;
            end else if (req_wait > 0) begin
                req_wait--;
                if (req_wait == 0) begin
                    chk({p, "_req_hold"}, tex.texture_request, 1);
                    tex.texture_data = line;
                    tex.texture_ack = 1'b1;
                    texack_cyc = cyc;
                end
            end
            if (write_o && !wrote) begin
                wrote = 1;
                chk({p, "_sb_nonempty"}, sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    g = sb.pop_front();
                    chk({p, "_color"}, color_o, g.color);
                    chk({p, "_alpha"}, a_o, g.a);
                    chk({p, "_px"}, pixel_x_o, g.x);
                    chk({p, "_py"}, pixel_y_o, g.y);
                    chk({p, "_pz"}, pixel_z_o, g.z);
                    chk({p, "_written_not_discard"}, g.disc, 0);
                end
                chk({p, "_write_cycle"}, cyc, t.tex_en ? texack_cyc + 1 : 1);
                chk({p, "_req_drop"}, tex.texture_request, 0);
                if (t.tex_en) begin
                    tex.texture_data = ~line;
                    tex.texture_ack = 1'b1;
                end
                ack_wait = t.ack_dly;
                if (ack_wait == 0) begin
                    ack_i = 1'b1;
                    ackset_cyc = cyc;
                end
            end else if (wrote && ack_wait > 0) begin
                chk({p, "_write_hold"}, write_o, 1);
                ack_wait--;
                if (ack_wait == 0) begin
                    ack_i = 1'b1;
                    ackset_cyc = cyc;
                end
            end
            if (ack_o) begin
                if (wrote) begin
                    chk({p, "_ack_cycle"}, cyc, ackset_cyc + 1);
                end else begin
                    chk({p, "_ack_cycle"}, cyc, texack_cyc + 1);
                    chk({p, "_sb_nonempty"}, sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        g = sb.pop_front();
                        chk({p, "_discard"}, g.disc, 1);
                    end
                end
                chk({p, "_wrote"}, wrote, !t.e_disc);
                chk({p, "_write_low_at_ack"}, write_o, 0);
                if (!t.tex_en) chk({p, "_no_request"}, req_seen, 0);
                write_i = 1'b0;
                done = 1;
            end
        end
        chk({p, "_done"}, done, 1);
        tex.texture_ack = 1'b0;
        ack_i = 1'b0;
        tex.wbm_busy = 1'b0;
        step();
        chk({p, "_ack_one_pulse"}, ack_o, 0);
    endtask

    initial begin : main
        int n_ack, n_wr;
        bit got;
        texture_enable_i = 0; tex_32bpp_i = 0; colorkey_enable_i = 0; colorkey_i = 0;
        tex0_base_i = 0; tex0_size_x_i = 0; tex0_size_y_i = 0;
        pixel_x_i = 0; pixel_y_i = 0; pixel_z_i = 0; u_i = 0; v_i = 0; a_i = 0; color_i = 0;
        write_i = 0; ack_i = 0;
        tex.texture_ack = 0; tex.texture_data = '0; tex.wbm_busy = 0;

        //               te b32 ck ck_key         base          sx  sy  u    v   a      color          raw            busy dly e_addr         e_sel          e_color        e_a    disc
        vt[0] = mk(0, 0, 1, 32'h11223344, 32'h0,        0,  0,  0,   0,  8'h80, 32'h11223344, 32'h0,        0,   2,  32'h0,         32'h0,         32'h11223344, 8'h80, 0);
        vt[1] = mk(1, 1, 0, 32'h0,        32'h1000,     64, 64, 3,   2,  8'h80, 32'h0BADBEEF, 32'hFF00FF00, 7,   0,  32'h1200,      32'h0000F000,  32'hFF00FF00, 8'h80, 0);
        vt[2] = mk(1, 0, 0, 32'h0,        32'h2000,     64, 64, 200, 1,  8'h40, 32'h0,        32'h0000F800, 0,   1,  32'h20E0,      32'hC0000000,  32'hFFFF0000, 8'h40, 0);
        vt[3] = mk(1, 1, 1, 32'hFFFF00FF, 32'h0,        16, 16, 1,   0,  8'h80, 32'h12345678, 32'hFFFF00FF, 0,   0,  32'h0,         32'h000000F0,  32'h0,        8'h0,  1);
        vt[4] = mk(1, 1, 1, 32'hFFFF00FF, 32'h0,        16, 16, 1,   0,  8'hFF, 32'h0,        32'h80FF00FE, 0,   1,  32'h0,         32'h000000F0,  32'h80FF00FE, 8'h80, 0);
        vt[5] = mk(1, 0, 1, 32'hFF00FF00, 32'h100,      8,  8,  4,   20, 8'h7F, 32'h0,        32'h000007E0, 0,   0,  32'h160,       32'h03000000,  32'h0,        8'h0,  1);
        vt[6] = mk(1, 0, 0, 32'h0,        32'h2,        10, 5,  2,   3,  8'h33, 32'h0,        32'h00001234, 0,   1,  32'h40,        32'h0000000C,  32'hFF1045A5, 8'h33, 0);
        vt[7] = mk(1, 1, 0, 32'h0,        32'h7FE0,     0,  0,  5,   5,  8'hC8, 32'h0,        32'h40123456, 0,   0,  32'h7FE0,      32'h0000000F,  32'h40123456, 8'h32, 0);
        vt[8] = mk(1, 1, 0, 32'h0,        32'hFFFFFFF0, 16, 16, 7,   0,  8'h80, 32'h0,        32'h00ABCDEF, 0,   0,  32'h0,         32'h0000F000,  32'h00ABCDEF, 8'h00, 0);
        vt[9] = mk(1, 0, 1, 32'hFFFF0000, 32'h0,        4,  4,  3,   3,  8'h80, 32'h0,        32'h0000001F, 0,   0,  32'h0,         32'hC0000000,  32'hFF0000FF, 8'h80, 0);

        #2 rst_ni = 1'b0;
        repeat (3) step();
        chk("rst_write_o", write_o, 0);
        chk("rst_ack_o", ack_o, 0);
        chk("rst_request", tex.texture_request, 0);
        chk("rst_addr", tex.texture_addr, 0);
        chk("rst_sel", tex.texture_sel, 0);
        chk("rst_color", color_o, 0);
        chk("rst_alpha", a_o, 0);
        chk("rst_pixel", {pixel_x_o, pixel_y_o}, 0);
        chk("rst_pixel_z", pixel_z_o, 0);
        rst_ni = 1'b1;
        step();

        for (int i = 0; i < 10; i++) run_vec(vt[i], i);

        // back-to-back pixels with write_i and ack_i held high: one per 3 cycles
        texture_enable_i = 0; color_i = 32'hCAFEF00D; a_i = 8'h11;
        write_i = 1'b1; ack_i = 1'b1;
        n_ack = 0; n_wr = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            n_ack += int'(ack_o);
            n_wr  += int'(write_o);
        end
        write_i = 1'b0; ack_i = 1'b0;
        chk("thru_ack_pulses", n_ack, 3);
        chk("thru_writes", n_wr, 3);
        chk("thru_color", color_o, 32'hCAFEF00D);
        step();

        // reset while a texture request is outstanding
        drive_pixel(vt[1], 30);
        write_i = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            got = tex.texture_request;
        end
        chk("rstreq_request_seen", got, 1);
        write_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("rstreq_request", tex.texture_request, 0);
        chk("rstreq_write_ack", {write_o, ack_o}, 0);
        chk("rstreq_addr_sel", tex.texture_addr | tex.texture_sel, 0);
        chk("rstreq_color", color_o, 0);
        chk("rstreq_alpha_px", {a_o, pixel_x_o}, 0);
        step();
        step();
        rst_ni = 1'b1;
        tex.texture_data = build_line(vt[1]);
        tex.texture_ack = 1'b1;
        step();
        tex.texture_ack = 1'b0;
        got = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            got = got | write_o | ack_o | tex.texture_request;
        end
        chk("rstreq_stray_ack_ignored", got, 0);
        chk("rstreq_color_still_0", color_o, 0);
        run_vec(vt[0], 31);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
